// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: computes a - b - borrow_in K bits per clock, LSB slice first,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
    parameter int unsigned N = 8,
    parameter int unsigned K = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         zero,
    output logic         overflow
);

    generate
        if (K == 0 || (N % K) != 0) begin : gen_bad_params
            $error("serial_subtractor: N must be a non-zero multiple of K");
        end
    endgenerate

    localparam int unsigned NSlices = N / K;
    localparam int unsigned CntW    = $clog2(NSlices + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NSlices - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            brw_q, brw_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    diff_q, diff_d;
    logic            bor_q, bor_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;

    logic [K:0]      slice_sub;
    logic [N-1:0]    acc_next;

    // Operands shift right each RUN cycle so the active slice is always at bit 0; results
    // enter the accumulator from the top and are fully aligned after N/K cycles.
    always_comb begin
        slice_sub = {1'b0, a_q[K-1:0]} - {1'b0, b_q[K-1:0]} - (K+1)'(brw_q);
        acc_next  = (acc_q >> K) | (N'(slice_sub[K-1:0]) << (N - K));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        diff_d  = diff_q;
        bor_d   = bor_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = borrow_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> K;
                b_d   = b_q >> K;
                brw_d = slice_sub[K];
                acc_d = acc_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // On the last slice the operand sign bits sit at bit K-1.
                    diff_d  = acc_next;
                    bor_d   = slice_sub[K];
                    zero_d  = (acc_next == '0);
                    ovf_d   = (a_q[K-1] != b_q[K-1]) && (acc_next[N-1] != a_q[K-1]);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            diff_q  <= '0;
            bor_q   <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            diff_q  <= diff_d;
            bor_q   <= bor_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign diff       = diff_q;
    assign borrow_out = bor_q;
    assign zero       = zero_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle N-bit subtractor that computes a − b − borrow_in, K bits per clock, least-significant slice first. It is the inverse-operation companion to the team's combinational ripple-carry adder. It trades area for latency, for datapaths where a full-width borrow chain is not wanted. Operands enter and results leave through valid/ready handshakes, so the block can sit between registered pipeline stages.

## Interface
- N, default 8: operand and result width in bits.
- K, default 1: bits processed per RUN cycle. N must be a multiple of K; any other combination is illegal and must not elaborate.
- clk  input  1: single clock; all state changes on its rising edge.
- rst  input  1: asynchronous, active-high reset.
- in_valid  input  1: operands on a, b, borrow_in are valid.
- in_ready  output  1: block can accept operands.
- a  input  N: minuend, unsigned or two's complement.
- b  input  N: subtrahend.
- borrow_in  input  1: borrow into bit 0.
- out_valid  output  1: result outputs are valid.
- out_ready  input  1: consumer accepts the result.
- diff  output  N: (a − b − borrow_in) mod 2^N.
- borrow_out  output  1: 1 iff a < b + borrow_in, compared as unsigned.
- zero  output  1: 1 iff diff == 0.
- overflow  output  1: signed overflow, defined as (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready = 1, out_valid = 0.
  - When in_valid = 1, capture a, b and borrow_in into internal registers, clear the slice counter, go to RUN.
  - When in_valid = 0, stay in IDLE.
- RUN
  - in_ready = 0, out_valid = 0.
  - Each cycle, take the lowest unprocessed K-bit slice and compute slice = a_slice − b_slice − borrow.
  - Store the K result bits at the matching position; register the slice borrow for the next cycle. The first slice uses the captured borrow_in.
  - After N/K slices, load diff, borrow_out (the final borrow), zero and overflow into output registers together, then go to DONE.
- DONE
  - out_valid = 1, in_ready = 0.
  - When out_ready = 1, go to IDLE.
  - When out_ready = 0, hold the state and all outputs unchanged.
- in_valid is ignored outside IDLE; operands presented then are not captured.
- diff, borrow_out, zero and overflow change only at the RUN→DONE transition. They keep their values after the handshake until the next result is loaded.
- Inputs a, b and borrow_in may change freely after the capture edge without affecting the result.

## Timing
- in_ready and out_valid are decoded from registered state only; there is no combinational path from any input to any output.
- Accept edge T is the edge where IDLE and in_valid are both 1. out_valid rises at edge T + N/K. Examples: N=8, K=1 gives 8 cycles; N=8, K=4 gives 2 cycles.
- With out_ready held at 1, the minimum issue interval is N/K + 2 cycles: one IDLE, N/K RUN, one DONE.
- Reset values: state = IDLE, so in_ready = 1 and out_valid = 0. diff = 0, borrow_out = 0, zero = 0, overflow = 0. Internal operand, borrow and counter registers are also 0.
- Reset asserted in RUN or DONE aborts the operation immediately. No out_valid pulse follows, and the partial result is discarded.
- After reset deasserts, operands may be accepted on the first rising edge.
- borrow_in = 1 with a == b gives diff = all ones, borrow_out = 1.
- The slice counter is wide enough for N/K and does not wrap before DONE.

## Test plan
- N=8, K=1: a=0x05, b=0x03, borrow_in=0 → diff=0x02, borrow_out=0, zero=0, overflow=0; out_valid rises exactly 8 cycles after the accept edge.
- a=0x03, b=0x05, borrow_in=0 → diff=0xFE, borrow_out=1, overflow=0. Then a=0x80, b=0x01 → diff=0x7F, borrow_out=0, overflow=1.
- a=0x00, b=0x00, borrow_in=1 → diff=0xFF, borrow_out=1, zero=0. Then a=0x10, b=0x0F, borrow_in=1 → diff=0x00, zero=1, borrow_out=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and drive in_valid=1 with new operands throughout → out_valid stays 1, outputs unchanged, in_ready=0, new operands not captured. Release out_ready → IDLE, in_ready=1 on the next cycle.
- Reset pulse on the 3rd RUN cycle → out_valid stays 0, in_ready=1 and all outputs 0 immediately. The next operation (0x05 − 0x03) completes correctly.
- N=8, K=4: a=0xA5, b=0x5A, borrow_in=0 → diff=0x4B, borrow_out=0, overflow=1, latency 2 cycles. Back-to-back operations issue every 4 cycles with out_ready=1.
